// File: rtl/linebuffer_scanout_if.sv
// Line-buffer scanout bundle: line control and display enable, BRAM read port,
// and the pixel stream towards the palette stage.
interface linebuffer_scanout_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WORD_W = 128,
  parameter int unsigned LW_W   = 11
);
  logic              line_start;
  logic              line_sel;
  logic [LW_W-1:0]   line_width;
  logic              hdouble;
  logic              de;
  logic [ADDR_W-1:0] addr_pix;
  logic [WORD_W-1:0] colour_pix;
  logic [PIX_W-1:0]  pix_colour;
  logic              pix_valid;
  logic              line_done;
  logic              underrun;

  // Timing generator plus BRAM side
  modport master (
    output line_start, line_sel, line_width, hdouble, de, colour_pix,
    input  addr_pix, pix_colour, pix_valid, line_done, underrun
  );

  // Scanout engine side
  modport slave (
    input  line_start, line_sel, line_width, hdouble, de, colour_pix,
    output addr_pix, pix_colour, pix_valid, line_done, underrun
  );
endinterface

// File: rtl/linebuffer_scanout.sv
// Pixel-clock read side of the ping-pong line buffer: prefetches two BRAM words per
// line and serialises them one pixel per display slot, with optional 2x doubling.
module linebuffer_scanout #(
  parameter int unsigned      PIX_W  = 8,
  parameter int unsigned      ADDR_W = 7,
  parameter logic [PIX_W-1:0] BORDER = '0
) (
  input  logic clk_pix,
  input  logic rst_pix_n,
  linebuffer_scanout_if.slave bus
);

  localparam int unsigned WORD_W       = 128;
  localparam int unsigned PIX_PER_WORD = WORD_W / PIX_W;
  localparam int unsigned IDX_W        = $clog2(PIX_PER_WORD);
  localparam int unsigned WIDX_W       = ADDR_W - 1;
  localparam int unsigned CNT_W        = 11;
  localparam int unsigned MAX_PIX      = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_READY,
    S_ACTIVE
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q;
  logic [CNT_W-1:0]    width_q;
  logic                hdouble_q;
  logic                rep_q;
  logic [WORD_W-1:0]   shift_q;
  logic [WORD_W-1:0]   hold_q;
  logic [IDX_W-1:0]    pix_idx_q;
  logic [WIDX_W-1:0]   word_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          reload_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [PIX_W-1:0]    pix_colour_q;
  logic                pix_valid_q;
  logic                line_done_q;
  logic                underrun_q;

  logic                slot_c;
  logic                consume_c;
  logic                underrun_c;
  logic                last_idx_c;
  logic                last_pix_c;
  logic                word_switch_c;
  logic [CNT_W-1:0]    cnt_nxt_c;

  // Out-of-range widths are capped at MAX_PIX so the line always terminates
  assign cnt_nxt_c     = cnt_q + CNT_W'(1);
  assign last_idx_c    = (pix_idx_q == IDX_W'(PIX_PER_WORD - 1));
  assign last_pix_c    = (cnt_nxt_c == width_q) || (cnt_nxt_c == CNT_W'(MAX_PIX));
  assign word_switch_c = consume_c && last_idx_c;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state and per-cycle slot decode; line_start overrides everything
  always_comb begin
    state_d    = state_q;
    slot_c     = 1'b0;
    consume_c  = 1'b0;
    underrun_c = 1'b0;
    unique case (state_q)
      S_FETCH0: begin
        state_d    = S_FETCH1;
        underrun_c = bus.de;
      end
      S_FETCH1: begin
        state_d    = S_READY;
        underrun_c = bus.de;
      end
      S_READY: begin
        state_d    = S_ACTIVE;
        underrun_c = bus.de;
      end
      S_ACTIVE: begin
        slot_c    = bus.de;
        consume_c = bus.de && (!hdouble_q || rep_q);
        if (consume_c && last_pix_c) state_d = S_IDLE;
      end
      default: state_d = state_q;
    endcase
    if (bus.line_start) state_d = S_FETCH0;
  end

  // Datapath: line parameters, word registers, counters and registered outputs
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sel_q        <= 1'b0;
      width_q      <= '0;
      hdouble_q    <= 1'b0;
      rep_q        <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      pix_idx_q    <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      reload_q     <= '0;
      addr_q       <= '0;
      pix_colour_q <= BORDER;
      pix_valid_q  <= 1'b0;
      line_done_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      pix_colour_q <= slot_c ? shift_q[PIX_W-1:0] : BORDER;
      pix_valid_q  <= slot_c;
      line_done_q  <= consume_c && last_pix_c;
      underrun_q   <= underrun_c;
      if (bus.line_start) begin
        sel_q     <= bus.line_sel;
        width_q   <= bus.line_width;
        hdouble_q <= bus.hdouble;
        addr_q    <= {bus.line_sel, WIDX_W'(0)};
        rep_q     <= 1'b0;
        cnt_q     <= '0;
        pix_idx_q <= '0;
        word_q    <= '0;
        reload_q  <= '0;
      end else begin
        // BRAM data for a newly issued address arrives two cycles after the switch
        reload_q <= {reload_q[0], word_switch_c};
        if (reload_q[1])           hold_q  <= bus.colour_pix;
        if (state_q == S_FETCH0)   addr_q  <= {sel_q, WIDX_W'(1)};
        if (state_q == S_FETCH1)   shift_q <= bus.colour_pix;
        if (state_q == S_READY)    hold_q  <= bus.colour_pix;
        if (slot_c && hdouble_q)   rep_q   <= ~rep_q;
        if (consume_c) begin
          cnt_q     <= cnt_nxt_c;
          pix_idx_q <= pix_idx_q + IDX_W'(1);
          if (last_idx_c) begin
            shift_q <= hold_q;
            word_q  <= word_q + WIDX_W'(1);
            addr_q  <= {sel_q, word_q + WIDX_W'(2)};
          end else begin
            shift_q <= shift_q >> PIX_W;
          end
        end
      end
    end
  end

  assign bus.addr_pix   = addr_q;
  assign bus.pix_colour = pix_colour_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.line_done  = line_done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_linebuffer_scanout.sv
// Scoreboard bench for linebuffer_scanout: a line-level reference model predicts
// every output cycle; a monitor pops and compares on each DUT output cycle.
module tb_linebuffer_scanout;

  logic clk_pix = 1'b0;
  logic rst_pix_n;
  always #5 clk_pix = ~clk_pix;

  linebuffer_scanout_if bus ();

  linebuffer_scanout #(.PIX_W(8), .ADDR_W(7), .BORDER(8'h00)) dut (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .bus      (bus)
  );

  // Line-buffer BRAM: registered read, data one cycle after the address
  logic [127:0] mem [128];
  always @(posedge clk_pix) bus.colour_pix <= mem[bus.addr_pix];

  typedef struct packed {
    logic [7:0] colour;
    logic       valid;
    logic       done;
    logic       under;
  } exp_t;

  typedef struct packed {
    logic [7:0] colour;
    logic       last;
  } slot_t;

  exp_t  exp_q [$];
  slot_t slot_q[$];
  bit    busy;
  int    since;
  int    errors = 0;
  int    checks = 0;

  // Expected slot sequence of a whole line, straight from the buffer contents
  task automatic build_line(input bit sel, input int width, input bit hd);
    logic [127:0] w;
    slot_t s;
    slot_q.delete();
    for (int i = 0; i < width; i++) begin
      w = mem[sel * 64 + (i / 16) % 64];
      s.colour = w[(i % 16) * 8 +: 8];
      if (hd) begin
        s.last = 1'b0;
        slot_q.push_back(s);
      end
      s.last = (i == width - 1);
      slot_q.push_back(s);
    end
  endtask

  // One pixel-clock cycle: drive inputs, predict the output it produces
  task automatic cycle(input bit ls, input bit sel, input int width, input bit hd, input bit de);
    exp_t  e;
    slot_t s;
    bus.line_start = ls;
    bus.line_sel   = sel;
    bus.line_width = 11'(width);
    bus.hdouble    = hd;
    bus.de         = de;
    e = '{colour: 8'h00, valid: 1'b0, done: 1'b0, under: 1'b0};
    if (busy && since >= 1 && since <= 3) begin
      e.under = de;
    end else if (busy && since >= 4 && de && slot_q.size() > 0) begin
      s = slot_q.pop_front();
      e.colour = s.colour;
      e.valid  = 1'b1;
      e.done   = s.last;
      if (s.last) busy = 1'b0;
    end
    if (busy) since++;
    if (ls) begin
      build_line(sel, width, hd);
      busy  = 1'b1;
      since = 1;
    end
    @(posedge clk_pix);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n, input bit de);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0, de);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_addr"},   32'(bus.addr_pix),   32'h0);
    check_val({tag, "_colour"}, 32'(bus.pix_colour), 32'h0);
    check_val({tag, "_valid"},  32'(bus.pix_valid),  32'h0);
    check_val({tag, "_done"},   32'(bus.line_done),  32'h0);
    check_val({tag, "_under"},  32'(bus.underrun),   32'h0);
  endtask

  task automatic randomize_mem();
    logic [127:0] w;
    for (int a = 0; a < 128; a++) begin
      for (int j = 0; j < 4; j++) w[32 * j +: 32] = $urandom;
      mem[a] = w;
    end
  endtask

  // Monitor: the DUT presents one output record per cycle
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk_pix);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.pix_colour, bus.pix_valid, bus.line_done, bus.underrun};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out t=%0t: got colour=%h valid=%b done=%b under=%b, expected colour=%h valid=%b done=%b under=%b",
                   $time, a.colour, a.valid, a.done, a.under, e.colour, e.valid, e.done, e.under);
        end
      end
    end
  end

  initial begin
    int width;
    bit sel;
    bit hd;
    int n;
    logic [127:0] w;
    rst_pix_n      = 1'b0;
    bus.line_start = 1'b0;
    bus.line_sel   = 1'b0;
    bus.line_width = '0;
    bus.hdouble    = 1'b0;
    bus.de         = 1'b0;
    busy           = 1'b0;
    since          = 0;
    for (int a = 0; a < 128; a++) begin
      for (int k = 0; k < 16; k++) w[8 * k +: 8] = 8'(a * 16 + k);
      mem[a] = w;
    end
    repeat (2) @(posedge clk_pix);
    #1;
    check_reset("reset");
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(posedge clk_pix);
    #1;

    // Plain line on the upper half, with address walk
    cycle(1'b1, 1'b1, 32, 1'b0, 1'b0);
    check_val("addr_word0", 32'(bus.addr_pix), 32'h40);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_val("addr_word1", 32'(bus.addr_pix), 32'h41);
    run(2, 1'b0);
    run(16, 1'b1);
    check_val("addr_word2", 32'(bus.addr_pix), 32'h42);
    run(16, 1'b1);
    run(4, 1'b1);

    // Pixel doubling
    cycle(1'b1, 1'b0, 16, 1'b1, 1'b0);
    run(3, 1'b0);
    run(34, 1'b1);

    // Alternating display enable
    cycle(1'b1, 1'b1, 48, 1'b0, 1'b0);
    run(3, 1'b0);
    for (int i = 0; i < 98; i++) cycle(1'b0, 1'b0, 0, 1'b0, (i % 2) == 0);

    // Display enable during prefetch
    cycle(1'b1, 1'b0, 20, 1'b0, 1'b0);
    run(30, 1'b1);

    // Full-width line over random contents
    randomize_mem();
    cycle(1'b1, 1'b0, 1024, 1'b0, 1'b0);
    run(3, 1'b0);
    run(1030, 1'b1);

    // Reset in the middle of a line
    cycle(1'b1, 1'b1, 64, 1'b0, 1'b0);
    run(3, 1'b0);
    run(20, 1'b1);
    @(negedge clk_pix);
    #1;
    rst_pix_n = 1'b0;
    busy = 1'b0;
    slot_q.delete();
    #1;
    check_reset("midreset");
    @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;
    cycle(1'b1, 1'b1, 16, 1'b0, 1'b0);
    run(3, 1'b0);
    run(18, 1'b1);

    // Abort mid-line, then restart coinciding with the final pixel
    cycle(1'b1, 1'b0, 40, 1'b0, 1'b0);
    run(3, 1'b0);
    run(10, 1'b1);
    cycle(1'b1, 1'b1, 24, 1'b1, 1'b1);
    run(3, 1'b0);
    run(50, 1'b1);
    cycle(1'b1, 1'b0, 16, 1'b0, 1'b0);
    run(3, 1'b0);
    run(15, 1'b1);
    cycle(1'b1, 1'b1, 1, 1'b0, 1'b1);
    run(3, 1'b0);
    run(3, 1'b1);

    // Random lines with random display-enable gaps
    for (int l = 0; l < 25; l++) begin
      randomize_mem();
      sel = 1'($urandom_range(0, 1));
      hd  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       width = $urandom_range(1, 17);
        default: width = $urandom_range(1, 300);
      endcase
      cycle(1'b1, sel, width, hd, ($urandom_range(0, 3) != 0));
      n = 0;
      while (busy && n < 8 * width + 50) begin
        cycle(1'b0, 1'b0, 0, 1'b0, ($urandom_range(0, 3) != 0));
        n++;
      end
      check_val("line_ended", 32'(busy), 32'h0);
      run($urandom_range(0, 3), 1'b1);
    end

    run(3, 1'b0);
    @(negedge clk_pix);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
